// File: rtl/rv_pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch sequencer (master)
// and instruction memory (slave). Single outstanding request.
interface rv_pc_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/rv_pc_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Optional performance counters enabled by defining RV_PC_FETCH_PERF_EN.
module rv_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   nextpc,
    input  logic                pc_update,
    output logic [ADDR_W-1:0]   pc,
    rv_pc_fetch_if.master       imem,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic                fetch_err,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t state;

    // Request is a pure decode of state; address is the PC itself, so it
    // cannot move while a request is pending.
    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= ADDR_W'(RESET_PC);
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.imem_gnt) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        inst       <= imem.imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (pc_update) begin
                        inst_valid <= 1'b0;
                        if (nextpc[1:0] == 2'b00) begin
                            pc    <= nextpc;
                            state <= S_REQ;
                        end else begin
                            // Misaligned target is fatal until reset; PC keeps
                            // the faulting instruction's address.
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    inst_valid <= 1'b0;
                    fetch_err  <= 1'b1;
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef RV_PC_FETCH_PERF_EN
    logic fetch_evt, stall_evt;

    assign fetch_evt = (state == S_WAIT) &&  imem.imem_rvalid;
    assign stall_evt = ((state == S_REQ)  && !imem.imem_gnt) ||
                       ((state == S_WAIT) && !imem.imem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_evt) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_pc_fetch.sv
// Directed + randomized bench for rv_pc_fetch; a transaction-level model
// tracks expected PC, fetched word and performance counts.
module tb_rv_pc_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          AW     = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] nextpc;
    logic          pc_update;
    logic [AW-1:0] pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic          fetch_err;
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_stall_cnt;

    rv_pc_fetch_if #(.ADDR_W(AW)) bus ();

    rv_pc_fetch #(.RESET_PC(RST_PC), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .nextpc         (nextpc),
        .pc_update      (pc_update),
        .pc             (pc),
        .imem           (bus.master),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .fetch_err      (fetch_err),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef RV_PC_FETCH_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic chk_perf(input string tag);
        chk({tag, "_pfetch"}, perf_fetch_cnt, pexp(exp_fetch));
        chk({tag, "_pstall"}, perf_stall_cnt, pexp(exp_stall));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n     = 1'b1;
        exp_pc    = RST_PC;
        exp_fetch = 0;
        exp_stall = 0;
    endtask

    // One fetch transaction from S_REQ: d1 cycles without grant, grant,
    // d2 cycles without data, then data. Optional pc_update noise throughout.
    task automatic fetch(input int d1, input int d2, input logic [31:0] data, input bit noise);
        for (int i = 0; i < d1; i++) begin
            chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
            chk("addr_hold", bus.imem_addr, exp_pc);
            chk("iv_req", {31'd0, inst_valid}, 32'd0);
            bus.imem_gnt = 1'b0;
            pc_update = noise;
            nextpc    = 32'h0000_0100;
            tick();
            pc_update = 1'b0;
            exp_stall++;
        end
        chk("req_gnt", {31'd0, bus.imem_req}, 32'd1);
        chk("addr_gnt", bus.imem_addr, exp_pc);
        bus.imem_gnt = 1'b1;
        pc_update    = noise;
        tick();
        bus.imem_gnt = 1'b0;
        pc_update    = 1'b0;
        for (int i = 0; i < d2; i++) begin
            chk("req_wait", {31'd0, bus.imem_req}, 32'd0);
            chk("pc_wait", pc, exp_pc);
            chk("iv_wait", {31'd0, inst_valid}, 32'd0);
            pc_update = noise;
            tick();
            pc_update = 1'b0;
            exp_stall++;
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        exp_fetch++;
        chk("iv_valid", {31'd0, inst_valid}, 32'd1);
        chk("inst", inst, data);
        chk("req_valid", {31'd0, bus.imem_req}, 32'd0);
        chk("pc_valid", pc, exp_pc);
        chk_perf("fetch");
    endtask

    task automatic commit(input logic [31:0] np);
        nextpc    = np;
        pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        if (np[1:0] == 2'b00) begin
            exp_pc = np;
            chk("pc_commit", pc, exp_pc);
            chk("iv_commit", {31'd0, inst_valid}, 32'd0);
            chk("req_commit", {31'd0, bus.imem_req}, 32'd1);
            chk("addr_commit", bus.imem_addr, exp_pc);
            chk("err_commit", {31'd0, fetch_err}, 32'd0);
        end else begin
            chk("err_set", {31'd0, fetch_err}, 32'd1);
            chk("pc_err", pc, exp_pc);
            chk("req_err", {31'd0, bus.imem_req}, 32'd0);
            chk("iv_err", {31'd0, inst_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        rst_n           = 1'b0;
        nextpc          = '0;
        pc_update       = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset state
        do_reset(2);
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_iv", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk_perf("rst");

        // Minimum-latency fetch, then hold in VALID without commit
        fetch(0, 0, 32'h0000_0013, 1'b0);
        repeat (2) begin
            tick();
            chk("valid_hold_iv", {31'd0, inst_valid}, 32'd1);
            chk("valid_hold_inst", inst, 32'h0000_0013);
        end
        commit(32'h0000_0040);

        // Stalled grant and data
        do_reset(1);
        fetch(5, 3, $urandom, 1'b0);
        chk("t3_stall", perf_stall_cnt, pexp(32'd8));
        chk("t3_fetch", perf_fetch_cnt, pexp(32'd1));
        commit($urandom & 32'hFFFF_FFFC);

        // pc_update outside VALID must be ignored
        fetch(2, 2, 32'hCAFE_0001, 1'b1);
        commit(32'h0000_0200);

        // Top-of-address-space target and wrap back to zero
        fetch(1, 0, $urandom, 1'b0);
        commit(32'hFFFF_FFFC);
        fetch(0, 1, $urandom, 1'b0);
        commit(32'h0000_0000);

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  $urandom, 1'($urandom_range(0, 1)));
            commit($urandom & 32'hFFFF_FFFC);
        end

        // Reset while a response is outstanding; stale data after release
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        chk("t6_in_wait", {31'd0, bus.imem_req}, 32'd0);
        do_reset(1);
        chk("t6_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t6_addr", bus.imem_addr, RST_PC);
        chk("t6_inst_clr", inst, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        exp_stall++;
        chk("t6_iv", {31'd0, inst_valid}, 32'd0);
        chk("t6_inst", inst, 32'd0);
        fetch(1, 1, 32'h0051_0113, 1'b0);

        // Misaligned target: sticky error, further commits ignored
        commit(32'h0000_0042);
        repeat (2) begin
            tick();
            chk("t4_err_hold", {31'd0, fetch_err}, 32'd1);
            chk("t4_req_hold", {31'd0, bus.imem_req}, 32'd0);
        end
        w = exp_pc;
        nextpc    = 32'h0000_0080;
        pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        chk("t4_pc_ignored", pc, w);
        chk("t4_err_still", {31'd0, fetch_err}, 32'd1);
        chk("t4_iv", {31'd0, inst_valid}, 32'd0);
        chk_perf("t4");
        do_reset(1);
        chk("t4_err_clr", {31'd0, fetch_err}, 32'd0);
        chk("t4_req_back", {31'd0, bus.imem_req}, 32'd1);
        chk("t4_addr_back", bus.imem_addr, RST_PC);
        fetch(0, 0, 32'h0000_0073, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
